// File: rtl/down_sampler_pkg.sv
// Shared types and sizing helpers for the 2:1 octave down-sampler.
package ds_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_KEEP = 2'd1,
    S_DROP = 2'd2
  } state_t;

  localparam int DEF_IN_WIDTH  = 1600;
  localparam int DEF_IN_HEIGHT = 1200;
  localparam int DEF_PIX_W     = 8;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 31; i >= 1; i--) begin
      if ((longint'(1) << i) >= longint'(n)) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/down_sampler_if.sv
// FIFO-side signal bundle of the down-sampler: upstream pop port and downstream push port.
interface down_sampler_if #(parameter int PIX_W = 8);
  // Upstream: rd_en pops when the FIFO is non-empty; din is qualified by valid one
  // cycle later. Downstream: valid_out is the push strobe; out_full leaves 2 entries spare.
  logic [PIX_W-1:0] din;
  logic             valid;
  logic             empty;
  logic             rd_en;
  logic             out_full;
  logic [PIX_W-1:0] dout;
  logic             valid_out;
  logic             frame_done;

  modport master (
    output din, valid, empty, out_full,
    input  rd_en, dout, valid_out, frame_done
  );

  modport slave (
    input  din, valid, empty, out_full,
    output rd_en, dout, valid_out, frame_done
  );
endinterface

// File: rtl/ds_raster_counter.sv
// Raster column/row counter with end-of-row and end-of-frame flags; advances on adv.
module ds_raster_counter
  import ds_pkg::*;
#(
  parameter  int WIDTH  = DEF_IN_WIDTH,
  parameter  int HEIGHT = DEF_IN_HEIGHT,
  localparam int CW     = clog2(WIDTH),
  localparam int RW     = clog2(HEIGHT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adv,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          eol,
  output logic          eof
);

  assign eol = (col == CW'(WIDTH - 1));
  assign eof = eol && (row == RW'(HEIGHT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (adv) begin
      if (eol) begin
        col <= '0;
        row <= eof ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/down_sampler.sv
// 2:1 decimator in both axes for the octave pyramid.
// Define DOWN_SAMPLER_AVG_EN to average horizontal pixel pairs instead of picking the even one.
module down_sampler
  import ds_pkg::*;
#(
  parameter  int IN_WIDTH  = DEF_IN_WIDTH,
  parameter  int IN_HEIGHT = DEF_IN_HEIGHT,
  parameter  int PIX_W     = DEF_PIX_W,
  localparam int CW        = clog2(IN_WIDTH),
  localparam int RW        = clog2(IN_HEIGHT)
) (
  input  logic           clk,
  input  logic           rst,
  down_sampler_if.slave  bus,
  output state_t         state_dbg,
  output logic [CW-1:0]  col_dbg,
  output logic [RW-1:0]  row_dbg
);

  state_t        state_q, state_d;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          eol, eof;
  logic          keep_pix;

  ds_raster_counter #(.WIDTH(IN_WIDTH), .HEIGHT(IN_HEIGHT)) u_cnt (
    .clk (clk),
    .rst (rst),
    .adv (bus.valid),
    .col (col),
    .row (row),
    .eol (eol),
    .eof (eof)
  );

  // Pop whenever there is data and the downstream has headroom for the in-flight pixel.
  assign bus.rd_en = !rst && !bus.empty && !bus.out_full;

  assign state_dbg = state_q;
  assign col_dbg   = col;
  assign row_dbg   = row;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.valid) begin
      unique case (state_q)
        S_IDLE:  state_d = S_KEEP;
        S_KEEP:  if (eol) state_d = S_DROP;
        S_DROP:  if (eol) state_d = eof ? S_IDLE : S_KEEP;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // S_IDLE's first pixel is row 0, col 0, so it belongs to a kept row.
  assign keep_pix = bus.valid && (state_q != S_DROP);

`ifdef DOWN_SAMPLER_AVG_EN
  logic [PIX_W-1:0] hold_q;
  logic [PIX_W:0]   pair_sum;

  assign pair_sum = {1'b0, hold_q} + {1'b0, bus.din} + (PIX_W+1)'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q         <= '0;
      bus.dout       <= '0;
      bus.valid_out  <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.frame_done <= bus.valid && eof;
      bus.valid_out  <= 1'b0;
      if (keep_pix) begin
        if (!col[0]) begin
          hold_q <= bus.din;
        end else begin
          bus.dout      <= pair_sum[PIX_W:1];
          bus.valid_out <= 1'b1;
        end
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.dout       <= '0;
      bus.valid_out  <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.frame_done <= bus.valid && eof;
      bus.valid_out  <= 1'b0;
      if (keep_pix && !col[0]) begin
        bus.dout      <= bus.din;
        bus.valid_out <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_down_sampler.sv
// Directed bench for down_sampler on a 4x4 frame: vector table plus reset/stall/FIFO sequences.
`timescale 1ns/1ps
module tb_down_sampler;
  import ds_pkg::*;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PW = 8;
  localparam int CW = clog2(W);
  localparam int RW = clog2(H);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  down_sampler_if #(.PIX_W(PW)) bus ();
  state_t        state_dbg;
  logic [CW-1:0] col_dbg;
  logic [RW-1:0] row_dbg;

  down_sampler #(.IN_WIDTH(W), .IN_HEIGHT(H), .PIX_W(PW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg),
    .col_dbg   (col_dbg),
    .row_dbg   (row_dbg)
  );

  typedef struct {
    logic          v;
    logic [PW-1:0] d;
    logic          ev;
    logic [PW-1:0] ed;
    logic          efd;
    state_t        es;
  } vec_t;

  vec_t          vecs[48];
  int            n_vecs;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] obs_q[$];
  logic [PW-1:0] up_q[$];
  logic [PW-1:0] frame_px[16];
  int            checks   = 0;
  int            failures = 0;
  int            fd_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sample();
    if (bus.valid_out === 1'b1) obs_q.push_back(bus.dout);
    if (bus.frame_done === 1'b1) fd_count++;
  endtask

  task automatic send_pixel(input logic [PW-1:0] d);
    bus.valid = 1'b1;
    bus.din   = d;
    @(posedge clk);
    #1;
    sample();
    bus.valid = 1'b0;
  endtask

  task automatic compare_queue(input string name);
    check({name, "_count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0)
      check(name, obs_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    obs_q.delete();
  endtask

  // Upstream FIFO model: pop is decided from rd_en before the edge, data arrives after it.
  task automatic fifo_step(input logic full_now, output logic popped);
    bus.out_full = full_now;
    bus.empty    = (up_q.size() == 0);
    @(negedge clk);
    popped = bus.rd_en;
    @(posedge clk);
    #1;
    sample();
    if (popped) begin
      bus.valid = 1'b1;
      bus.din   = up_q.pop_front();
    end else begin
      bus.valid = 1'b0;
    end
  endtask

  initial begin
    logic [PW-1:0] last;
    logic          keep, p;
    int            r, c, rd_hi, budget;
    state_t        es;

    bus.din = '0; bus.valid = 1'b0; bus.empty = 1'b0; bus.out_full = 1'b0;

    // Frame pass 0 without stalls, pass 1 with a gap after every pixel.
    n_vecs = 0;
    last   = '0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 16; i++) begin
        r    = i / W;
        c    = i % W;
        keep = (r % 2 == 0) && (c % 2 == 0);
        if (keep) last = PW'(i);
        if (i == 15)     es = S_IDLE;
        else if (c == 3) es = (r % 2 == 0) ? S_DROP : S_KEEP;
        else             es = (r % 2 == 0) ? S_KEEP : S_DROP;
        vecs[n_vecs] = '{1'b1, PW'(i), keep, last, (i == 15), es};
        n_vecs++;
        if (pass == 1) begin
          vecs[n_vecs] = '{1'b0, 8'hA5, 1'b0, last, 1'b0, es};
          n_vecs++;
        end
      end
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_en", bus.rd_en, 0);
    check("rst_dout", bus.dout, 0);
    check("rst_valid_out", bus.valid_out, 0);
    check("rst_frame_done", bus.frame_done, 0);
    check("rst_state", 32'(state_dbg), 32'(S_IDLE));
    check("rst_col", col_dbg, 0);
    check("rst_row", row_dbg, 0);
    rst = 1'b0;
    #1;
    check("rd_en_ready", bus.rd_en, 1);
    bus.empty = 1'b1;
    #1;
    check("rd_en_empty", bus.rd_en, 0);
    bus.empty = 1'b0; bus.out_full = 1'b1;
    #1;
    check("rd_en_full", bus.rd_en, 0);
    bus.out_full = 1'b0;

    // Table: frame of pixels 0..15 -> 0,2,8,10, with and without gaps
    for (int k = 0; k < n_vecs; k++) begin
      bus.valid = vecs[k].v;
      bus.din   = vecs[k].d;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_valid_out", k), bus.valid_out, vecs[k].ev);
      check($sformatf("vec%0d_dout", k), bus.dout, vecs[k].ed);
      check($sformatf("vec%0d_frame_done", k), bus.frame_done, vecs[k].efd);
      check($sformatf("vec%0d_state", k), 32'(state_dbg), 32'(vecs[k].es));
    end
    bus.valid = 1'b0;

    // Pair-average corner values
    frame_px = '{8'd10, 8'd21, 8'd255, 8'd254,
                 8'd1,  8'd2,  8'd3,   8'd4,
                 8'd0,  8'd2,  8'd4,   8'd6,
                 8'd7,  8'd8,  8'd9,   8'd10};
`ifdef DOWN_SAMPLER_AVG_EN
    exp_q = '{8'd16, 8'd255, 8'd1, 8'd5};
`else
    exp_q = '{8'd10, 8'd255, 8'd0, 8'd4};
`endif
    fd_count = 0;
    for (int i = 0; i < 16; i++) send_pixel(frame_px[i]);
    compare_queue("avg_frame");
    check("avg_frame_done_count", fd_count, 1);

    // FIFO handshake with out_full held 20 cycles mid-row
    for (int i = 0; i < 16; i++) up_q.push_back(PW'(i));
    fd_count = 0;
    repeat (6) fifo_step(1'b0, p);
    rd_hi = 0;
    repeat (20) begin
      fifo_step(1'b1, p);
      if (p) rd_hi++;
    end
    check("rd_en_during_full", rd_hi, 0);
    budget = 0;
    do begin
      fifo_step(1'b0, p);
      budget++;
    end while ((up_q.size() > 0 || bus.valid) && budget < 100);
    check("fifo_drain_in_budget", (budget < 100), 1);
    bus.valid = 1'b0; bus.empty = 1'b0; bus.out_full = 1'b0;
    exp_q = '{8'd0, 8'd2, 8'd8, 8'd10};
    compare_queue("fifo_frame");
    check("fifo_frame_done_count", fd_count, 1);

    // Reset mid-frame after pixel 6, then a fresh frame 100..115
    for (int i = 0; i <= 6; i++) send_pixel(PW'(i));
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_dout", bus.dout, 0);
    check("midrst_valid_out", bus.valid_out, 0);
    check("midrst_frame_done", bus.frame_done, 0);
    check("midrst_rd_en", bus.rd_en, 0);
    check("midrst_state", 32'(state_dbg), 32'(S_IDLE));
    check("midrst_col", col_dbg, 0);
    check("midrst_row", row_dbg, 0);
    rst = 1'b0;
    obs_q.delete();
    fd_count = 0;
    for (int i = 100; i <= 115; i++) send_pixel(PW'(i));
    exp_q = '{8'd100, 8'd102, 8'd108, 8'd110};
    compare_queue("post_rst_frame");
    check("post_rst_frame_done_count", fd_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
